sc_data_responder: RTL and testbench

Data-side responder for the single-cycle rv32im core. It serves the core's data port: a word address, a 4-bit byte write mask, write data, and combinational read data. It decodes each access to one of three targets: a byte-maskable RAM, a UART transmitter with a small FIFO, and a free-running cycle counter. Reads are combinational so the core sees read data in the same cycle; all state changes happen on the rising clock edge.

---
 rtl/sc_data_responder.sv | 118 +++++++++++
 tb/tb_sc_data_responder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sc_data_responder.sv
// sc_data_responder: data-port responder for the single-cycle core.
// It serves byte-maskable RAM, a FIFO-fed 8N1 UART transmitter and a free-running cycle counter.
module sc_data_responder #(
   parameter int unsigned RAM_WORDS  = 1024,
   parameter logic [31:0] UART_BASE  = 32'h3000_0000,
   parameter int unsigned CLK_DIV    = 217,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [3:0]  write_mask,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        uart_tx,
   output logic        access_fault
);
   localparam int unsigned AW = $clog2(RAM_WORDS);
   localparam int unsigned FW = $clog2(FIFO_DEPTH);
   localparam int unsigned TW = $clog2(CLK_DIV);
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
   localparam logic [29:0] BASE_W = UART_BASE[31:2];
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   logic [31:0] ram [RAM_WORDS];
   logic [7:0] fifo [FIFO_DEPTH];
   state_t state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic [FW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [FW:0] cnt_q, cnt_d;
   logic [31:0] cyc_q, cyc_d;
   logic ovf_q, ovf_d, tx_q, tx_d, fault_q, fault_d;
   logic is_ram, is_tx, is_st, is_cyc, is_unm;
   logic empty, full, bit_end, push_req, push, pop;
   assign is_ram = addr < RAM_BYTES;
   assign is_tx = !is_ram && addr[31:2] == BASE_W;
   assign is_st = !is_ram && addr[31:2] == BASE_W + 30'd1;
   assign is_cyc = !is_ram && addr[31:2] == BASE_W + 30'd2;
   assign is_unm = !(is_ram || is_tx || is_st || is_cyc);
   assign empty = cnt_q == '0;
   assign full = cnt_q == (FW+1)'(FIFO_DEPTH);
   assign bit_end = timer_q == TW'(CLK_DIV - 1);
   // A full FIFO still accepts a push when the FSM frees a slot in the same cycle.
   assign pop = !empty && (state_q == IDLE || (state_q == STOP && bit_end));
   assign push_req = is_tx && write_mask[0];
   assign push = push_req && (!full || pop);
   assign read_data = is_ram ? ram[addr[AW+1:2]]
                    : is_st ? {28'b0, ovf_q, state_q != IDLE, empty, full}
                    : is_cyc ? cyc_q : '0;
   assign uart_tx = tx_q;
   assign access_fault = fault_q;
   always_comb begin
      state_d = state_q;
      bit_d = bit_q;
      shift_d = shift_q;
      timer_d = (state_q == IDLE || bit_end) ? '0 : timer_q + TW'(1);
      unique case (state_q)
         IDLE: if (pop) begin
            state_d = START;
            shift_d = fifo[rd_q];
         end
         START: if (bit_end) begin
            state_d = DATA;
            bit_d = '0;
         end
         DATA: if (bit_end) begin
            shift_d = shift_q >> 1;
            bit_d = bit_q + 3'd1;
            state_d = bit_q == 3'd7 ? STOP : DATA;
         end
         STOP: if (bit_end) begin
            state_d = pop ? START : IDLE;
            shift_d = pop ? fifo[rd_q] : shift_q;
         end
      endcase
      tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
      wr_d = wr_q + FW'(push);
      rd_d = rd_q + FW'(pop);
      cnt_d = cnt_q + (FW+1)'(push) - (FW+1)'(pop);
      ovf_d = (push_req && !push) ? 1'b1
            : (is_st && write_mask[0] && write_data[3]) ? 1'b0 : ovf_q;
      fault_d = is_unm && |write_mask;
      cyc_d = cyc_q + 32'd1;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         timer_q <= '0;
         bit_q <= '0;
         shift_q <= '0;
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
         cyc_q <= '0;
         ovf_q <= 1'b0;
         tx_q <= 1'b1;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bit_q <= bit_d;
         shift_q <= shift_d;
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
         cyc_q <= cyc_d;
         ovf_q <= ovf_d;
         tx_q <= tx_d;
         fault_q <= fault_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) fifo[wr_q] <= write_data[7:0];
      for (int i = 0; i < 4; i++)
         if (is_ram && write_mask[i]) ram[addr[AW+1:2]][8*i +: 8] <= write_data[8*i +: 8];
   end
endmodule

// File: tb/tb_sc_data_responder.sv
// tb_sc_data_responder: directed checks of RAM lanes, UART frames, overflow, counter, faults and reset.
module tb_sc_data_responder;
   localparam logic [31:0] TXA = 32'h3000_0000;
   localparam logic [31:0] STA = 32'h3000_0004;
   localparam logic [31:0] CYA = 32'h3000_0008;
   logic clk = 1'b0, reset = 1'b1;
   logic [31:0] addr = '0, write_data = '0, read_data;
   logic [3:0] write_mask = '0;
   logic uart_tx, access_fault;
   int n_chk = 0, n_err = 0;
   sc_data_responder #(.CLK_DIV(4)) dut (
      .clk(clk), .reset(reset), .addr(addr), .write_mask(write_mask),
      .write_data(write_data), .read_data(read_data), .uart_tx(uart_tx),
      .access_fault(access_fault));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic acc(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
      addr = a;
      write_mask = m;
      write_data = d;
   endtask
   task automatic step();
      @(negedge clk);
   endtask
   function automatic logic frame_bit(input int p, input logic [7:0] b);
      int n;
      n = p / 4;
      return n == 0 ? 1'b0 : n < 9 ? b[n-1] : 1'b1;
   endfunction
   logic [7:0] bs [6] = '{8'hA1, 8'h3C, 8'hF0, 8'h0F, 8'h5A, 8'hC3};
   logic [7:0] rb [3] = '{8'hF7, 8'h12, 8'h34};
   initial begin
      int lows;
      logic e;
      repeat (2) step();
      reset = 1'b0;
      acc(STA, 4'h0, '0);
      #1;
      chk("rst_status", read_data, 32'h2);
      chk("rst_tx", {31'b0, uart_tx}, 32'h1);
      chk("rst_fault", {31'b0, access_fault}, 32'h0);
      acc(CYA, 4'h0, '0);
      #1 chk("cyc0", read_data, 32'd0);
      repeat (7) step();
      #1 chk("cyc7", read_data, 32'd7);
      step();
      acc(CYA, 4'hF, 32'hFFFF_FFFF);
      #1 chk("cyc8_wr", read_data, 32'd8);
      step();
      acc(CYA, 4'h0, '0);
      #1 chk("cyc9", read_data, 32'd9);
      step();
      acc(32'h10, 4'hF, 32'hAABB_CCDD);
      step();
      acc(32'h10, 4'h2, 32'h0000_1100);
      #1 chk("ram_same_cycle", read_data, 32'hAABB_CCDD);
      step();
      acc(32'h10, 4'h0, '0);
      #1 chk("ram_lane", read_data, 32'hAABB_11DD);
      acc(32'h13, 4'h0, '0);
      #1 chk("ram_low_bits", read_data, 32'hAABB_11DD);
      step();
      acc(32'h2000_0000, 4'hF, 32'hDEAD_BEEF);
      #1 chk("unm_read", read_data, 32'h0);
      chk("unm_pre", {31'b0, access_fault}, 32'h0);
      step();
      acc(32'h2000_0000, 4'h0, '0);
      #1 chk("unm_fault", {31'b0, access_fault}, 32'h1);
      step();
      #1 chk("unm_one_cycle", {31'b0, access_fault}, 32'h0);
      step();
      #1 chk("unm_read_nofault", {31'b0, access_fault}, 32'h0);
      acc(32'h1000, 4'hF, 32'h1);
      step();
      acc(STA, 4'h0, '0);
      #1 chk("ram_end_fault", {31'b0, access_fault}, 32'h1);
      for (int c = 0; c <= 45; c++) begin
         step();
         if (c == 0) acc(TXA, 4'h1, 32'h55);
         else acc(STA, 4'h0, '0);
         #1;
         e = c < 2 ? 1'b1 : c < 42 ? frame_bit(c - 2, 8'h55) : 1'b1;
         chk($sformatf("f1_tx_c%0d", c), {31'b0, uart_tx}, {31'b0, e});
         if (c == 0) chk("f1_txdata_read", read_data, 32'h0);
         if (c == 3 || c == 41) chk($sformatf("f1_st_c%0d", c), read_data, 32'h6);
         if (c == 42 || c == 45) chk($sformatf("f1_st_c%0d", c), read_data, 32'h2);
      end
      for (int c = 0; c <= 210; c++) begin
         step();
         if (c < 6) acc(TXA, 4'h1, {24'h0, bs[c]});
         else if (c == 7) acc(STA, 4'h1, 32'h8);
         else acc(STA, 4'h0, '0);
         #1;
         e = c < 2 ? 1'b1 : c < 202 ? frame_bit((c - 2) % 40, bs[(c - 2) / 40]) : 1'b1;
         chk($sformatf("ov_tx_c%0d", c), {31'b0, uart_tx}, {31'b0, e});
         if (c == 6) chk("ov_status", read_data, 32'hD);
         if (c == 8) chk("ov_cleared", read_data, 32'h5);
         if (c == 205) chk("ov_idle", read_data, 32'h2);
      end
      for (int c = 0; c <= 19; c++) begin
         step();
         if (c < 3) acc(TXA, 4'h1, {24'h0, rb[c]});
         else acc(STA, 4'h0, '0);
      end
      #1 chk("rm_bit3", {31'b0, uart_tx}, 32'h0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      chk("rm_tx_high", {31'b0, uart_tx}, 32'h1);
      chk("rm_status", read_data, 32'h2);
      lows = 0;
      for (int c = 0; c < 100; c++) begin
         step();
         #1 if (!uart_tx) lows++;
      end
      chk("rm_no_frames", 32'(lows), 32'h0);
      chk("rm_status_end", read_data, 32'h2);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
